// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch unit bus - program counter, instruction memory, redirect and decode handshake.
interface fetch_unit_if;
    logic [31:0] pc;
    logic        pc_write_enable;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    modport master (
        input  pc, imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready,
        output pc_write_enable, next_pc, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );
    modport slave (
        output pc, imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready,
        input  pc_write_enable, next_pc, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a ring-buffer fetch queue and redirect flush.
module fetch_unit #(
    parameter int QUEUE_DEPTH = 2
) (
    input logic          clock,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef logic [PW+1:0] sum_t;
    localparam cnt_t DEPTH = cnt_t'(QUEUE_DEPTH);
    logic [31:0] addr_q [QUEUE_DEPTH];
    logic [31:0] addr_d [QUEUE_DEPTH];
    logic [31:0] data_q [QUEUE_DEPTH];
    logic [31:0] data_d [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] filled_q, filled_d;
    ptr_t head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
    cnt_t cnt_q, cnt_d, ucnt_q, ucnt_d, drop_q, drop_d;
    sum_t in_flight;
    logic redir, accept, fill, pop;
    always_comb begin
        redir = bus.redirect_valid & !reset;
        bus.imem_req_valid = !reset & !bus.redirect_valid & (cnt_q < DEPTH) & (drop_q == '0);
        bus.imem_req_addr = bus.pc;
        accept = bus.imem_req_valid & bus.imem_req_ready;
        bus.pc_write_enable = redir | accept;
        bus.next_pc = redir ? (bus.redirect_pc & 32'hFFFF_FFFC) : bus.pc + 32'd4;
        fill = bus.imem_resp_valid & (drop_q == '0) & (ucnt_q != '0);
        bus.inst_valid = !reset & (cnt_q != '0) & filled_q[head_q];
        bus.inst = data_q[head_q];
        bus.inst_pc = addr_q[head_q];
        pop = bus.inst_valid & bus.inst_ready & !bus.redirect_valid;
        // stale responses still owed by memory: earlier drops plus unfilled entries, less one landing now
        in_flight = sum_t'(drop_q) + sum_t'(ucnt_q);
        addr_d = addr_q;
        data_d = data_q;
        filled_d = filled_q;
        if (pop) filled_d[head_q] = 1'b0;
        if (accept) begin
            addr_d[tail_q] = bus.pc;
            filled_d[tail_q] = 1'b0;
        end
        if (fill) begin
            data_d[fptr_q] = bus.imem_resp_data;
            filled_d[fptr_q] = 1'b1;
        end
        if (redir) filled_d = '0;
        head_d = redir ? '0 : head_q + ptr_t'(pop);
        tail_d = redir ? '0 : tail_q + ptr_t'(accept);
        fptr_d = redir ? '0 : fptr_q + ptr_t'(fill);
        cnt_d = redir ? '0 : cnt_q + cnt_t'(accept) - cnt_t'(pop);
        ucnt_d = redir ? '0 : ucnt_q + cnt_t'(accept) - cnt_t'(fill);
        drop_d = redir ? ((in_flight == '0) ? '0 : cnt_t'(in_flight - sum_t'(bus.imem_resp_valid)))
                       : drop_q - cnt_t'(bus.imem_resp_valid & (drop_q != '0));
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            fptr_q <= '0;
            cnt_q <= '0;
            ucnt_q <= '0;
            drop_q <= '0;
            filled_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fptr_q <= fptr_d;
            cnt_q <= cnt_d;
            ucnt_q <= ucnt_d;
            drop_q <= drop_d;
            filled_q <= filled_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with an in-order memory model and an instruction scoreboard.
module tb_fetch_unit;
    localparam int D = 2;
    logic clock = 1'b0;
    logic reset;
    fetch_unit_if bus ();
    fetch_unit #(.QUEUE_DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic filled;} ent_t;
    typedef struct {logic [31:0] addr; int due;} req_t;
    ent_t sb [$];
    req_t memq [$];
    logic [31:0] acc_log [$];
    logic [31:0] pop_log [$];
    int n_chk = 0, n_fail = 0, cyc_n = 0, lat = 1, drop_m = 0;
    logic [31:0] pc_r = 32'h0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        if (memq.size() != 0 && memq[0].due <= cyc_n) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data = 32'h0;
        end
        bus.pc = pc_r;
        #1;
    endtask

    task automatic tick();
        logic rv, erv, eiv, ewe, we;
        logic [31:0] npc;
        rv = bus.redirect_valid;
        erv = !reset && !rv && sb.size() < D && drop_m == 0;
        eiv = !reset && sb.size() != 0 && sb[0].filled;
        ewe = !reset && (rv || (erv && bus.imem_req_ready));
        chk("req_valid", 32'(bus.imem_req_valid), 32'(erv));
        chk("inst_valid", 32'(bus.inst_valid), 32'(eiv));
        chk("pc_we", 32'(bus.pc_write_enable), 32'(ewe));
        chk("req_addr", bus.imem_req_addr, pc_r);
        if (ewe) chk("next_pc", bus.next_pc, rv ? {bus.redirect_pc[31:2], 2'b00} : pc_r + 32'd4);
        if (eiv) begin
            chk("inst_pc", bus.inst_pc, sb[0].addr);
            chk("inst", bus.inst, sb[0].data);
        end
        if (reset) begin
            sb.delete();
            memq.delete();
            drop_m = 0;
        end else if (rv) begin
            sb.delete();
            drop_m = memq.size();
        end else begin
            if (bus.imem_resp_valid) begin
                if (drop_m > 0) drop_m--;
                else for (int i = 0; i < sb.size(); i++) if (!sb[i].filled) begin
                    sb[i].filled = 1'b1;
                    break;
                end
            end
            if (eiv && bus.inst_ready) begin
                pop_log.push_back(sb[0].addr);
                void'(sb.pop_front());
            end
            if (erv && bus.imem_req_ready) begin
                sb.push_back('{pc_r, mem_word(pc_r), 1'b0});
                memq.push_back('{pc_r, cyc_n + lat});
                acc_log.push_back(pc_r);
            end
        end
        we = bus.pc_write_enable;
        npc = bus.next_pc;
        @(posedge clock);
        cyc_n++;
        if (we) pc_r = npc;
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(logic [31:0] pc0);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        pc_r = pc0;
        repeat (2) cyc();
        reset = 1'b0;
        acc_log.delete();
        pop_log.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.pc = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b0;
        // streaming with single-cycle memory
        do_reset(32'h100);
        lat = 1;
        bus.inst_ready = 1'b1;
        run(10);
        chk("stream_req0", acc_log[0], 32'h100);
        chk("stream_req1", acc_log[1], 32'h104);
        chk("stream_req2", acc_log[2], 32'h108);
        chk("stream_pops", 32'(pop_log.size() >= 3), 32'd1);
        chk("stream_pop2", pop_log.size() >= 3 ? pop_log[2] : 32'hDEAD, 32'h108);
        // decode backpressure
        do_reset(32'h100);
        bus.inst_ready = 1'b0;
        run(6);
        chk("bp_accepts", 32'(acc_log.size()), 32'd2);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("bp_pc", pc_r, 32'h108);
        bus.inst_ready = 1'b1;
        cyc();
        chk("bp_resume", 32'(bus.imem_req_valid), 32'd1);
        run(6);
        // redirect with two requests outstanding
        do_reset(32'h1000);
        lat = 3;
        run(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h2002;
        settle();
        chk("rd_next_pc", bus.next_pc, 32'h2000);
        chk("rd_pc_we", 32'(bus.pc_write_enable), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        run(1);
        chk("rd_stall", 32'(bus.imem_req_valid), 32'd0);
        run(8);
        chk("rd_first_pc", pop_log.size() != 0 ? pop_log[0] : 32'hDEAD, 32'h2000);
        // redirect coincident with a response and a pop
        do_reset(32'h3000);
        lat = 2;
        bus.inst_ready = 1'b0;
        run(3);
        bus.inst_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h4000;
        settle();
        chk("co_resp", 32'(bus.imem_resp_valid), 32'd1);
        chk("co_head", 32'(bus.inst_valid), 32'd1);
        tick();
        bus.redirect_valid = 1'b0;
        settle();
        chk("co_empty", 32'(bus.inst_valid), 32'd0);
        chk("co_req", 32'(bus.imem_req_valid), 32'd1);
        chk("co_addr", bus.imem_req_addr, 32'h4000);
        tick();
        run(6);
        chk("co_pops", 32'(pop_log.size() != 0 && pop_log[0] == 32'h4000), 32'd1);
        // PC wraparound
        do_reset(32'hFFFF_FFFC);
        lat = 1;
        settle();
        chk("wrap_next_pc", bus.next_pc, 32'h0);
        chk("wrap_pc_we", 32'(bus.pc_write_enable), 32'd1);
        tick();
        run(5);
        chk("wrap_pop0", pop_log.size() >= 2 ? pop_log[0] : 32'hDEAD, 32'hFFFF_FFFC);
        chk("wrap_pop1", pop_log.size() >= 2 ? pop_log[1] : 32'hDEAD, 32'h0);
        // reset over a full queue with a redirect pending
        do_reset(32'h500);
        bus.inst_ready = 1'b0;
        run(4);
        chk("full_valid", 32'(bus.inst_valid), 32'd1);
        reset = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h7000;
        settle();
        chk("rst_req", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_we", 32'(bus.pc_write_enable), 32'd0);
        chk("rst_iv", 32'(bus.inst_valid), 32'd0);
        tick();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        settle();
        chk("post_iv", 32'(bus.inst_valid), 32'd0);
        chk("post_req", 32'(bus.imem_req_valid), 32'd1);
        chk("post_addr", bus.imem_req_addr, 32'h508);
        tick();
        bus.inst_ready = 1'b1;
        run(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2: entries in the fetch queue; power of two, >= 2.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising clock edge.
REQ-004 pc  input  32  current PC from program_counter.
REQ-005 pc_write_enable  output  1  program_counter write strobe.
REQ-006 next_pc  output  32  value written into program_counter when pc_write_enable=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  32  fetch address; always equals pc.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_resp_valid  input  1  response word valid, one cycle pulse per response.
REQ-011 imem_resp_data  input  32  instruction word.
REQ-012 redirect_valid  input  1  branch/jump/trap redirect from a later stage.
REQ-013 redirect_pc  input  32  redirect target.
REQ-014 inst_valid  output  1  instruction available to decode.
REQ-015 inst  output  32  instruction word at queue head.
REQ-016 inst_pc  output  32  address of inst.
REQ-017 inst_ready  input  1  decode consumes the head entry this cycle.

Function
REQ-018 Memory SHALL return responses in request order, exactly one per accepted request, at least 1 cycle after acceptance; the block needs no tag.
REQ-019 Fetch queue: QUEUE_DEPTH-entry ring; each entry holds {addr, data, filled}; an entry is allocated when a request is accepted (imem_req_valid & imem_req_ready) and filled by the next non-dropped response.
REQ-020 imem_req_valid = !reset & !redirect_valid & (allocated entries < QUEUE_DEPTH) & (drop_count == 0); occupancy is the registered value, no same-cycle pop bypass.
REQ-021 Once asserted, imem_req_valid SHALL stay high with unchanged imem_req_addr until accepted, except when withdrawn by redirect_valid or reset.
REQ-022 On request acceptance without redirect: pc_write_enable=1, next_pc=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000).
REQ-023 On redirect_valid=1 (not in reset): pc_write_enable=1; next_pc={redirect_pc[31:2],2'b00}; no request issued; all queue entries freed next cycle.
REQ-024 On redirect, drop_count <= (allocated-but-unfilled entries) minus 1 if imem_resp_valid is high that same cycle, floored at 0; this counts responses still in flight.
REQ-025 While drop_count > 0, each imem_resp_valid decrements drop_count and its data is discarded.
REQ-026 Otherwise pc_write_enable=0 and next_pc=pc+4.
REQ-027 inst_valid = head entry allocated and filled; inst/inst_pc = head data/addr; a pop occurs when inst_valid & inst_ready & !redirect_valid.
REQ-028 A response and a pop in the same cycle both take effect; allocation, fill and pop may all occur in one cycle.
REQ-029 A response arriving with no unfilled entry and drop_count == 0 is a protocol violation and SHALL be ignored without changing state.
REQ-030 inst_ready while inst_valid=0 has no effect; inst_valid never depends combinationally on inst_ready.

Reset
REQ-031 During a cycle with reset=1: imem_req_valid=0, pc_write_enable=0, inst_valid=0.
REQ-032 After reset: queue empty, head/tail pointers 0, drop_count 0, all filled bits 0; reset has priority over redirect_valid and any handshake.
REQ-033 Reset mid-operation discards all queued and in-flight fetches; responses for requests accepted before reset SHALL NOT arrive afterwards (environment guarantee).

Verification
REQ-034 Streaming: pc=0x100, imem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0x100,0x104,0x108; inst_pc stream 0x100,0x104,0x108 with matching data; pc_write_enable each accept cycle.
REQ-035 Backpressure: inst_ready=0, QUEUE_DEPTH=2 -> exactly 2 requests accepted, then imem_req_valid=0 and pc frozen at 0x108 until inst_ready=1 pops an entry.
REQ-036 Redirect with 2 outstanding (3-cycle latency): redirect_pc=0x2002 -> next_pc=0x2000, drop_count=2, two stale responses discarded, next inst_pc=0x2000.
REQ-037 Redirect coincident with a response and a pop -> that response dropped, pop ignored, drop_count = unfilled-1, queue empty next cycle.
REQ-038 Wrap: pc=0xFFFFFFFC accepted -> next_pc=0x00000000.
REQ-039 Reset asserted with a full queue and redirect_valid=1 -> next cycle inst_valid=0, drop_count=0, imem_req_valid=1 at the reset pc.
